mux_nx1_pipe: RTL
=================

# mux_nx1_pipe

Parametrised N-input, W-bit selector with a registered, flow-controlled output stage. It replaces fixed-width combinational selects at pipeline-stage boundaries, such as register-destination and writeback-source selection, wherever the downstream stage can stall. Each transfer is selected, tagged with an out-of-range-select error flag, and buffered in a 2-entry skid buffer so that neither side sees a combinational ready path.

## Interface
Parameters:
- `W`, 5: data width per channel.
- `N`, 3: number of input channels; legal range 2..2^`SEL_W`.
- `SEL_W`, 2: select width.

Ports:
- `Clk`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `In`  in  N*W  packed channels; channel i occupies bits [i*W +: W].
- `Sel`  in  SEL_W  channel index, sampled with `InValid`.
- `InValid`  in  1  upstream has a transfer.
- `InReady`  out  1  block can accept a transfer; derived from registered occupancy only.
- `Out`  out  W  selected data of the head entry.
- `OutValid`  out  1  head entry present.
- `OutReady`  in  1  downstream accepts the head entry.
- `SelErr`  out  1  head entry was produced from `Sel` >= N.
- `ErrCount`  out  16  saturating count of accepted out-of-range selects; present only with `MUX_ERR_COUNT_EN`.

## Operation
- **Push.** A push occurs on the edge where `InValid` && `InReady`.
  - Entry data is `In[Sel*W +: W]` if `Sel` < N, otherwise `W'b0`.
  - Entry error bit is (`Sel` >= N).
- **Pop.** A pop occurs on the edge where `OutValid` && `OutReady`.
- **Buffer.** 2 entries, FIFO order, occupancy `cnt` in {0,1,2}.
  - State EMPTY (`cnt`=0): push → ONE.
  - State ONE (`cnt`=1): push only → FULL; pop only → EMPTY; push and pop together → ONE, with the new entry becoming head.
  - State FULL (`cnt`=2): pop → ONE. No push is possible, because `InReady`=0.
- **Handshake outputs.**
  - `InReady` = (`cnt` != 2).
  - `OutValid` = (`cnt` != 0).
- **Output when empty.** When `OutValid`=0, `Out`=0 and `SelErr`=0.
- **Input sampling.** `In` and `Sel` are don't-care when `InValid`=0. Upstream must hold `In`, `Sel` and `InValid` stable while `InValid`=1 and `InReady`=0.
- **Output hold.** `Out` and `SelErr` hold stable while `OutValid`=1 and `OutReady`=0.
- **Illegal parameters.** N > 2^`SEL_W` or N < 2 is a parameter error and is flagged by an elaboration-time check.

## Timing
- **Reset (asynchronous).** `cnt`=0, both entries cleared. This gives `OutValid`=0, `Out`=0, `SelErr`=0, `InReady`=1 and `ErrCount`=0.
- **Reset mid-operation.** Buffered entries are discarded and not delivered. The first post-reset push is accepted on the first rising edge after `Reset` deasserts.
- **Latency.** A push on edge k is visible on `Out`/`OutValid` after edge k. It can pop on edge k+1 at the earliest.
- **Throughput.** 1 transfer per cycle while `OutReady`=1.
- **Stall.** With `OutReady`=0, the block absorbs at most 2 transfers, then `InReady`=0 from the edge that made `cnt`=2.
- **Recovery after stall.** When `OutReady` rises with `cnt`=2, the pop on that edge makes `InReady`=1 in the following cycle (registered), never combinationally.

## Configuration
- `MUX_ERR_COUNT_EN` defined:
  - `ErrCount` port and 16-bit counter exist.
  - The counter increments by 1 on each push whose `Sel` >= N.
  - It saturates at 16'hFFFF.
  - It is cleared only by `Reset`.
- `MUX_ERR_COUNT_EN` undefined:
  - No `ErrCount` port and no counter logic.
  - `SelErr` is still produced per entry.

## Test plan
- **Basic select.** W=5, N=3. Push `In`={C=5'd7,B=5'd3,A=5'd21} with `Sel`=0,1,2 on consecutive cycles, `OutReady`=1 → `Out`=21,3,7 on the 3 cycles after each push, `SelErr`=0, `InReady` stays 1.
- **Out-of-range select.** Push with `Sel`=3 → `Out`=0, `SelErr`=1, `OutValid`=1. With the macro, `ErrCount` goes 0→1. The next legal push gives `SelErr`=0.
- **Backpressure.** `OutReady`=0, push values 1,2,3 on back-to-back cycles → only 1 and 2 accepted, `InReady`=0 after the second push, value 3 held upstream. `OutReady`=1 then → pops 1,2,3 in order with no loss or duplication.
- **Simultaneous push/pop at `cnt`=1.** Push and pop on the same edge → `cnt` stays 1, new value becomes head, `OutValid` stays 1.
- **Reset mid-stream.** With `cnt`=2, assert `Reset` asynchronously between edges → immediately `OutValid`=0, `Out`=0, `InReady`=1, `ErrCount`=0. After deassert, a push of 9 appears as `Out`=9 one edge later.
- **Saturation (macro on).** Force 65536 out-of-range pushes → `ErrCount` stays at 16'hFFFF, data path unaffected.

Source files
------------

// File: rtl/mux_nx1_pipe.sv
// N-input, W-bit selector feeding a 2-entry skid buffer with a flow-controlled output.
// Optional out-of-range select counter (ErrCount) is built when MUX_ERR_COUNT_EN is defined.
module mux_nx1_pipe #(
    parameter int W     = 5,
    parameter int N     = 3,
    parameter int SEL_W = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [N*W-1:0]   In,
    input  logic [SEL_W-1:0] Sel,
    input  logic             InValid,
    output logic             InReady,
    output logic [W-1:0]     Out,
    output logic             OutValid,
    input  logic             OutReady,
    output logic             SelErr
`ifdef MUX_ERR_COUNT_EN
    ,
    output logic [15:0]      ErrCount
`endif
);

    localparam int NCH = 1 << SEL_W;
    localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N);

    generate
        if (N < 2 || N > NCH) begin : g_bad_param
            $error("mux_nx1_pipe: N must lie in 2..2**SEL_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Channels beyond N read as zero so every Sel value indexes a defined slot.
    logic [W-1:0] chan [NCH];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            if (gi < N) begin : g_live
                assign chan[gi] = In[gi*W +: W];
            end else begin : g_pad
                assign chan[gi] = '0;
            end
        end
    endgenerate

    logic         sel_err;
    logic [W-1:0] sel_data;
    logic         push;
    logic         pop;

    state_t       state_reg;
    logic [W-1:0] head_data_reg;
    logic         head_err_reg;
    logic [W-1:0] tail_data_reg;
    logic         tail_err_reg;

    assign sel_err  = ({1'b0, Sel} >= N_LIM);
    assign sel_data = sel_err ? '0 : chan[Sel];

    assign InReady  = (state_reg != FULL);
    assign OutValid = (state_reg != EMPTY);
    assign Out      = head_data_reg;
    assign SelErr   = head_err_reg;

    assign push = InValid && InReady;
    assign pop  = OutValid && OutReady;

    // Vacated entries are zeroed so Out/SelErr read 0 whenever the buffer is empty.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg     <= EMPTY;
            head_data_reg <= '0;
            head_err_reg  <= 1'b0;
            tail_data_reg <= '0;
            tail_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (push) begin
                        head_data_reg <= sel_data;
                        head_err_reg  <= sel_err;
                        state_reg     <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_data_reg <= sel_data;
                        head_err_reg  <= sel_err;
                    end else if (push) begin
                        tail_data_reg <= sel_data;
                        tail_err_reg  <= sel_err;
                        state_reg     <= FULL;
                    end else if (pop) begin
                        head_data_reg <= '0;
                        head_err_reg  <= 1'b0;
                        state_reg     <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_data_reg <= tail_data_reg;
                        head_err_reg  <= tail_err_reg;
                        tail_data_reg <= '0;
                        tail_err_reg  <= 1'b0;
                        state_reg     <= ONE;
                    end
                end
                default: begin
                    head_data_reg <= '0;
                    head_err_reg  <= 1'b0;
                    tail_data_reg <= '0;
                    tail_err_reg  <= 1'b0;
                    state_reg     <= EMPTY;
                end
            endcase
        end
    end

`ifdef MUX_ERR_COUNT_EN
    logic [15:0] err_count_reg;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            err_count_reg <= '0;
        end else if (push && sel_err && (err_count_reg != 16'hFFFF)) begin
            err_count_reg <= err_count_reg + 16'd1;
        end
    end

    assign ErrCount = err_count_reg;
`endif

endmodule
